// File: rtl/frame_config_loader.sv
// Frame-based configuration write sequencer: turns a valid/ready stream of
// (address, bit) words into setup/strobe/hold write cycles for a grid_io tile.
module frame_config_loader #(
  parameter int ADDR_WIDTH    = 4,
  parameter int NUM_WORDS     = 16,
  parameter int STROBE_CYCLES = 1,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  input  logic [ADDR_WIDTH-1:0] bs_addr,
  input  logic                  bs_data,
  output logic                  enable,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  data_in,
  output logic                  busy,
  output logic                  config_done,
  output logic [CNT_WIDTH-1:0]  words_loaded
);

  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SW-1:0]        STROBE_LAST = SW'(STROBE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WORDS_MAX   = CNT_WIDTH'(NUM_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD, DONE} state_e;

  state_e                  state_q, state_d;
  logic [SW-1:0]           strobe_cnt_q, strobe_cnt_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic                    data_in_q, data_in_d;
  logic [CNT_WIDTH-1:0]    words_loaded_q, words_loaded_d;
  logic                    config_done_q, config_done_d;
  logic                    enable_q, enable_d;
  logic                    bs_ready_q, bs_ready_d;
  logic                    busy_q, busy_d;
  logic [CNT_WIDTH-1:0]    words_inc;

  assign words_inc = words_loaded_q + 1'b1;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d        = state_q;
    strobe_cnt_d   = strobe_cnt_q;
    address_d      = address_q;
    data_in_d      = data_in_q;
    words_loaded_d = words_loaded_q;
    config_done_d  = config_done_q;

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d        = LOAD;
            words_loaded_d = '0;
            config_done_d  = 1'b0;
          end
        end
        // bs_ready is high exactly while in LOAD, so bs_valid alone completes the handshake.
        LOAD: begin
          if (bs_valid) begin
            address_d = bs_addr;
            data_in_d = bs_data;
            state_d   = SETUP;
          end
        end
        SETUP: begin
          strobe_cnt_d = '0;
          state_d      = STROBE;
        end
        STROBE: begin
          if (strobe_cnt_q == STROBE_LAST) state_d = HOLD;
          else                             strobe_cnt_d = strobe_cnt_q + 1'b1;
        end
        HOLD: begin
          words_loaded_d = words_inc;
          if (words_inc == WORDS_MAX) begin
            state_d       = DONE;
            config_done_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Status outputs are registered copies of the next-state decode, so they
    // line up with the state they describe and never glitch.
    enable_d   = (state_d == STROBE);
    bs_ready_d = (state_d == LOAD);
    busy_d     = (state_d == LOAD) || (state_d == SETUP) ||
                 (state_d == STROBE) || (state_d == HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // drops enable immediately, independent of prog_clk.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q        <= IDLE;
      strobe_cnt_q   <= '0;
      address_q      <= '0;
      data_in_q      <= 1'b0;
      words_loaded_q <= '0;
      config_done_q  <= 1'b0;
      enable_q       <= 1'b0;
      bs_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      strobe_cnt_q   <= strobe_cnt_d;
      address_q      <= address_d;
      data_in_q      <= data_in_d;
      words_loaded_q <= words_loaded_d;
      config_done_q  <= config_done_d;
      enable_q       <= enable_d;
      bs_ready_q     <= bs_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign enable       = enable_q;
  assign bs_ready     = bs_ready_q;
  assign busy         = busy_q;
  assign address      = address_q;
  assign data_in      = data_in_q;
  assign config_done  = config_done_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Scoreboard bench for frame_config_loader: a default instance and a
// STROBE_CYCLES=3 / NUM_WORDS=4 instance share the stream inputs.
module tb_frame_config_loader;

  localparam int AW = 4;
  localparam int CW = 8;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic          p_reset, start, start_b, abort, bs_valid, bs_data;
  logic [AW-1:0] bs_addr;

  logic          bs_ready, enable, data_in, busy, config_done;
  logic [AW-1:0] address;
  logic [CW-1:0] words_loaded;

  logic          bs_ready_b, enable_b, data_in_b, busy_b, config_done_b;
  logic [AW-1:0] address_b;
  logic [CW-1:0] words_loaded_b;

  frame_config_loader dut (
    .prog_clk(prog_clk), .pReset(p_reset), .start(start), .abort(abort),
    .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_addr(bs_addr), .bs_data(bs_data),
    .enable(enable), .address(address), .data_in(data_in), .busy(busy),
    .config_done(config_done), .words_loaded(words_loaded)
  );

  frame_config_loader #(.STROBE_CYCLES(3), .NUM_WORDS(4)) dut_b (
    .prog_clk(prog_clk), .pReset(p_reset), .start(start_b), .abort(abort),
    .bs_valid(bs_valid), .bs_ready(bs_ready_b), .bs_addr(bs_addr), .bs_data(bs_data),
    .enable(enable_b), .address(address_b), .data_in(data_in_b), .busy(busy_b),
    .config_done(config_done_b), .words_loaded(words_loaded_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {address, data_in} for each write, pushed at the handshake.
  logic [AW:0] sb_a[$];
  logic [AW:0] sb_b[$];

  bit chk_period = 1'b0;
  int last_rise  = -1;

  // Instance A: every enable pulse is one cycle wide and carries the next queued word.
  initial begin : mon_a
    int          cyc;
    int          width;
    logic        en_prev;
    logic [AW:0] e;
    cyc = 0; width = 0; en_prev = 1'b0;
    forever begin
      @(negedge prog_clk);
      cyc++;
      if (enable && !en_prev) begin
        check("a_pulse_expected", 32'(sb_a.size() != 0), 1);
        if (sb_a.size() != 0) begin
          e = sb_a.pop_front();
          check("a_pulse_word", 32'({address, data_in}), 32'(e));
        end
        if (chk_period && last_rise >= 0) check("a_period", 32'(cyc - last_rise), 4);
        last_rise = cyc;
        width     = 1;
      end else if (enable) begin
        width++;
      end else if (en_prev) begin
        check("a_width", 32'(width), 1);
      end
      en_prev = enable;
    end
  end

  // Instance B: 3-cycle pulses, word stable from the cycle before rise to the cycle after fall.
  initial begin : mon_b
    int          width;
    logic        en_prev;
    logic [AW:0] prev_word;
    logic [AW:0] e;
    width = 0; en_prev = 1'b0; prev_word = '0;
    forever begin
      @(negedge prog_clk);
      if (enable_b || en_prev) check("b_stable", 32'({address_b, data_in_b}), 32'(prev_word));
      if (enable_b && !en_prev) begin
        check("b_pulse_expected", 32'(sb_b.size() != 0), 1);
        if (sb_b.size() != 0) begin
          e = sb_b.pop_front();
          check("b_pulse_word", 32'({address_b, data_in_b}), 32'(e));
        end
        width = 1;
      end else if (enable_b) begin
        width++;
      end else if (en_prev) begin
        check("b_width", 32'(width), 3);
      end
      en_prev   = enable_b;
      prev_word = {address_b, data_in_b};
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1;
    else     start   = 1'b1;
    @(negedge prog_clk);
    start   = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [AW-1:0] a, input logic d);
    int t;
    t = 0;
    bs_valid = 1'b1;
    bs_addr  = a;
    bs_data  = d;
    while (!(sel ? bs_ready_b : bs_ready) && t < 50) begin
      @(negedge prog_clk);
      t++;
    end
    check("ready_wait", 32'(sel ? bs_ready_b : bs_ready), 1);
    if (sel) sb_b.push_back({a, d});
    else     sb_a.push_back({a, d});
    @(negedge prog_clk);
  endtask

  initial begin : stim
    p_reset = 1'b1; start = 1'b0; start_b = 1'b0; abort = 1'b0;
    bs_valid = 1'b0; bs_addr = '0; bs_data = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("reset_outputs",
          32'({enable, bs_ready, busy, config_done, data_in, address, words_loaded}), 0);
    p_reset = 1'b0;
    @(negedge prog_clk);
    check("idle_after_reset", 32'({bs_ready, busy, enable}), 0);

    // 16 words back-to-back, addr i, data i[0]
    pulse_start(1'b0);
    check("t1_start", 32'({busy, bs_ready, config_done}), 32'(3'b110));
    last_rise  = -1;
    chk_period = 1'b1;
    for (int i = 0; i < 16; i++) send_word(1'b0, AW'(i), i[0]);
    bs_valid = 1'b0;
    @(negedge prog_clk);
    check("t1_last_strobe", 32'(enable), 1);
    @(negedge prog_clk);
    check("t1_last_hold", 32'({config_done, busy, words_loaded}), 32'({1'b0, 1'b1, 8'd15}));
    @(negedge prog_clk);
    check("t1_done", 32'({config_done, busy, words_loaded}), 32'({1'b1, 1'b0, 8'd16}));
    @(negedge prog_clk);
    check("t1_idle_sticky", 32'({config_done, bs_ready, busy}), 32'(3'b100));
    chk_period = 1'b0;

    // stall between words 3 and 4
    pulse_start(1'b0);
    check("t2_start_clears", 32'({config_done, words_loaded}), 0);
    for (int i = 0; i < 4; i++) send_word(1'b0, AW'(15 - i), ~i[0]);
    bs_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
    for (int k = 0; k < 10; k++) begin
      check("t2_stall", 32'({bs_ready, enable, address, words_loaded}),
            32'({1'b1, 1'b0, 4'd12, 8'd4}));
      @(negedge prog_clk);
    end
    for (int i = 4; i < 16; i++) send_word(1'b0, AW'(15 - i), ~i[0]);
    bs_valid = 1'b0;
    repeat (4) @(negedge prog_clk);
    check("t2_done", 32'({config_done, words_loaded}), 32'({1'b1, 8'd16}));

    // STROBE_CYCLES=3 instance
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) send_word(1'b1, AW'(i * 3 + 1), i[1]);
    bs_valid = 1'b0;
    repeat (5) @(negedge prog_clk);
    check("t3_done", 32'({config_done_b, busy_b, words_loaded_b}), 32'({1'b1, 1'b0, 8'd4}));
    @(negedge prog_clk);
    check("t3_idle", 32'({bs_ready_b, enable_b}), 0);

    // abort during STROBE of word 5
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) send_word(1'b0, AW'(i + 5), i[0]);
    bs_valid = 1'b0;
    @(negedge prog_clk);
    check("t4_in_strobe", 32'(enable), 1);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check("t4_aborted", 32'({enable, busy, bs_ready, config_done, words_loaded}),
          32'({4'b0000, 8'd4}));
    @(negedge prog_clk);
    check("t4_stays_idle", 32'({bs_ready, busy, words_loaded}), 32'({2'b00, 8'd4}));
    pulse_start(1'b0);
    check("t4_restart", 32'({busy, words_loaded}), 32'({1'b1, 8'd0}));
    send_word(1'b0, 4'h9, 1'b1);
    send_word(1'b0, 4'h3, 1'b0);
    bs_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("t4_resumed_count", 32'({bs_ready, words_loaded}), 32'({1'b1, 8'd2}));

    // asynchronous reset in the middle of a strobe
    send_word(1'b0, 4'hA, 1'b1);
    bs_valid = 1'b0;
    @(negedge prog_clk);
    check("t5_strobe_high", 32'(enable), 1);
    #2 p_reset = 1'b1;
    #1 check("t5_async_enable", 32'(enable), 0);
    @(negedge prog_clk);
    p_reset = 1'b0;
    @(negedge prog_clk);
    check("t5_outputs_zero",
          32'({enable, bs_ready, busy, config_done, data_in, address, words_loaded}), 0);

    // start while busy, then start+abort together in IDLE
    pulse_start(1'b0);
    send_word(1'b0, 4'h6, 1'b1);
    bs_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
    pulse_start(1'b0);
    check("t6_start_busy_ignored", 32'({bs_ready, busy, words_loaded}), 32'({2'b11, 8'd1}));
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check("t6_abort_idle", 32'({busy, bs_ready}), 0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t6_start_abort_ignored", 32'({bs_ready, enable, busy, words_loaded}),
            32'({3'b000, 8'd1}));
      @(negedge prog_clk);
    end

    check("sb_a_drained", 32'(sb_a.size()), 0);
    check("sb_b_drained", 32'(sb_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
